// File: rtl/aes_aud_pkg.sv
// Shared AES3 subframe layout, preamble codes and state encoding for the
// multichannel stream packer.
package aes_aud_pkg;

    localparam logic [3:0] BSYNC   = 4'h1;
    localparam logic [3:0] SF1SYNC = 4'h2;
    localparam logic [3:0] SF2SYNC = 4'h3;

    localparam int P_BIT     = 31;
    localparam int C_BIT     = 30;
    localparam int U_BIT     = 29;
    localparam int V_BIT     = 28;
    localparam int AUD_MSB   = 27;
    localparam int AUD_LSB   = 4;
    localparam int AUD_WIDTH = AUD_MSB - AUD_LSB + 1;

    localparam int AES_BLOCK_FRAMES = 192;
    localparam int FRAME_CNT_W      = $clog2(AES_BLOCK_FRAMES);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } pack_state_e;

    // Parity bit that makes the covered field plus P carry an even count of ones.
    function automatic logic even_parity(input logic [C_BIT-AUD_LSB:0] payload);
        return ^payload;
    endfunction

endpackage

// File: rtl/aud_frame_fifo.sv
// Synchronous frame FIFO with full/empty flags and an occupancy count.
module aud_frame_fifo #(
    parameter int DATA_W = 33,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q,  level_d;
    logic              push, pop;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign push = wr_en_i && !full_o;
    assign pop  = rd_en_i && !empty_o;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and level alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/aes_multichannel_stream_packer.sv
// Buffers whole multichannel audio frames and serialises them as AES3 subframes,
// one channel per beat, with block-level channel status and mute handling.
module aes_multichannel_stream_packer
    import aes_aud_pkg::*;
#(
    parameter int           C_NUM_CHANNELS   = 2,
    parameter int           C_SAMPLE_WIDTH   = 16,
    parameter int           C_FIFO_DEPTH     = 4,
    parameter logic [191:0] C_CHANNEL_STATUS = 192'h0
) (
    input  logic                                     m00_axis_aud_aclk,
    input  logic                                     m00_axis_aud_areset,
    input  logic [C_NUM_CHANNELS*C_SAMPLE_WIDTH-1:0] s_frame_tdata,
    input  logic                                     s_frame_tvalid,
    output logic                                     s_frame_tready,
    input  logic                                     mute,
    output logic [31:0]                              m00_axis_aud_tdata,
    output logic [2:0]                               m00_axis_aud_tid,
    output logic                                     m00_axis_aud_tvalid,
    input  logic                                     m00_axis_aud_tready,
    output logic [$clog2(C_FIFO_DEPTH):0]            fifo_level,
    output logic                                     block_wrap
);

    localparam int FRAME_W = C_NUM_CHANNELS * C_SAMPLE_WIDTH;
    localparam int ENTRY_W = FRAME_W + 1;
    localparam logic [2:0]             LAST_CHAN  = 3'(C_NUM_CHANNELS - 1);
    localparam logic [FRAME_CNT_W-1:0] LAST_FRAME = FRAME_CNT_W'(AES_BLOCK_FRAMES - 1);

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]     fifo_rd_data;

    pack_state_e            state_q, state_d;
    logic [ENTRY_W-1:0]     hold_q,  hold_d;
    logic [2:0]             chan_q,  chan_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic                   wrap_q,  wrap_d;

    logic                      handshake, last_chan;
    logic [C_SAMPLE_WIDTH-1:0] sample;
    logic [AUD_WIDTH-1:0]      audio_word;
    logic                      frame_mute;
    logic [31:0]               subframe;

    assign s_frame_tready = !fifo_full && !m00_axis_aud_areset;
    assign fifo_push      = s_frame_tvalid && s_frame_tready;

    aud_frame_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (C_FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (m00_axis_aud_aclk),
        .rst_i     (m00_axis_aud_areset),
        .wr_en_i   (fifo_push),
        .wr_data_i ({mute, s_frame_tdata}),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign handshake = (state_q == ST_SEND) && m00_axis_aud_tready;
    assign last_chan = (chan_q == LAST_CHAN);

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        chan_d   = chan_q;
        frame_d  = frame_q;
        wrap_d   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_rd_data;
                    chan_d   = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    if (!last_chan) begin
                        chan_d = chan_q + 3'd1;
                    end else begin
                        chan_d  = '0;
                        wrap_d  = (frame_q == LAST_FRAME);
                        frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + FRAME_CNT_W'(1);
                        // Chain straight into the next buffered frame so no idle beat appears.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            hold_d   = fifo_rd_data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aud_aclk) begin
        if (m00_axis_aud_areset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            chan_q  <= '0;
            frame_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            chan_q  <= chan_d;
            frame_q <= frame_d;
            wrap_q  <= wrap_d;
        end
    end

    // The subframe is derived purely from registered state, so it holds during a stall.
    always_comb begin
        sample     = hold_q[int'(chan_q)*C_SAMPLE_WIDTH +: C_SAMPLE_WIDTH];
        frame_mute = hold_q[FRAME_W];
        audio_word = '0;
        if (!frame_mute) audio_word[AUD_WIDTH-1 -: C_SAMPLE_WIDTH] = sample;

        subframe = '0;
        if (chan_q[0])           subframe[3:0] = SF2SYNC;
        else if (frame_q == '0)  subframe[3:0] = BSYNC;
        else                     subframe[3:0] = SF1SYNC;
        subframe[AUD_MSB:AUD_LSB] = audio_word;
        subframe[V_BIT]           = frame_mute;
        subframe[U_BIT]           = 1'b0;
        subframe[C_BIT]           = C_CHANNEL_STATUS[frame_q];
        subframe[P_BIT]           = even_parity(subframe[C_BIT:AUD_LSB]);
    end

    assign m00_axis_aud_tvalid = (state_q == ST_SEND);
    assign m00_axis_aud_tdata  = m00_axis_aud_tvalid ? subframe : 32'h0;
    assign m00_axis_aud_tid    = chan_q;
    assign block_wrap          = wrap_q;

endmodule

// File: tb/tb_aes_multichannel_stream_packer.sv
// Scoreboard bench: a 2-channel/16-bit packer for handshake, mute, backpressure and
// reset cases, and a 6-channel/24-bit packer for the channel-status block stream.
module tb_aes_multichannel_stream_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Independent AES subframe model: ones are counted bit by bit for parity.
    function automatic logic [31:0] exp_sub(input logic [23:0] word, input logic m,
                                            input int ch, input int frame, input logic c);
        logic [31:0] r;
        int ones;
        r = 32'h0;
        r[3:0] = (ch % 2 == 1) ? 4'h3 : ((frame % 192 == 0) ? 4'h1 : 4'h2);
        if (!m) r[27:4] = word;
        r[28] = m;
        r[30] = c;
        ones = 0;
        for (int i = 4; i < 31; i++) ones += int'(r[i]);
        r[31] = (ones % 2 == 1);
        return r;
    endfunction

    // ---------------- DUT 0: 2 channels x 16 bits, status all zero ----------------
    logic        rst0, s_valid0, s_ready0, mute0, tvalid0, tready0, wrap0;
    logic [31:0] s_data0, tdata0;
    logic [2:0]  tid0, level0;
    logic [34:0] q0[$];
    int          cnt0 = 0;

    aes_multichannel_stream_packer #(
        .C_NUM_CHANNELS(2), .C_SAMPLE_WIDTH(16), .C_FIFO_DEPTH(4), .C_CHANNEL_STATUS(192'h0)
    ) dut0 (
        .m00_axis_aud_aclk   (clk),
        .m00_axis_aud_areset (rst0),
        .s_frame_tdata       (s_data0),
        .s_frame_tvalid      (s_valid0),
        .s_frame_tready      (s_ready0),
        .mute                (mute0),
        .m00_axis_aud_tdata  (tdata0),
        .m00_axis_aud_tid    (tid0),
        .m00_axis_aud_tvalid (tvalid0),
        .m00_axis_aud_tready (tready0),
        .fifo_level          (level0),
        .block_wrap          (wrap0)
    );

    // ---------------- DUT 1: 6 channels x 24 bits, status bit 0 set ----------------
    logic         rst1, s_valid1, s_ready1, mute1, tvalid1, tready1, wrap1;
    logic [143:0] s_data1;
    logic [31:0]  tdata1;
    logic [2:0]   tid1, level1;
    logic [34:0]  q1[$];
    int           beats1 = 0;
    int           wrap_seen = 0;
    logic         wrap_due = 1'b0;

    aes_multichannel_stream_packer #(
        .C_NUM_CHANNELS(6), .C_SAMPLE_WIDTH(24), .C_FIFO_DEPTH(4), .C_CHANNEL_STATUS(192'h1)
    ) dut1 (
        .m00_axis_aud_aclk   (clk),
        .m00_axis_aud_areset (rst1),
        .s_frame_tdata       (s_data1),
        .s_frame_tvalid      (s_valid1),
        .s_frame_tready      (s_ready1),
        .mute                (mute1),
        .m00_axis_aud_tdata  (tdata1),
        .m00_axis_aud_tid    (tid1),
        .m00_axis_aud_tvalid (tvalid1),
        .m00_axis_aud_tready (tready1),
        .fifo_level          (level1),
        .block_wrap          (wrap1)
    );

    // ---------------- Monitors ----------------
    always @(negedge clk) begin
        if (!rst0 && tvalid0 && tready0) begin
            if (q0.size() == 0) begin
                fail_now("dut0_unexpected_beat");
            end else begin
                logic [34:0] e;
                e = q0.pop_front();
                check("dut0_tdata", tdata0, e[31:0]);
                check("dut0_tid", tid0, e[34:32]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst1) begin
            if (wrap_due) begin
                check("dut1_block_wrap_pulse", wrap1, 1);
                if (wrap1) wrap_seen++;
                wrap_due = 1'b0;
            end else if (wrap1) begin
                fail_now("dut1_block_wrap_spurious");
            end
            if (tvalid1 && tready1) begin
                if (q1.size() == 0) begin
                    fail_now("dut1_unexpected_beat");
                end else begin
                    logic [34:0] e;
                    e = q1.pop_front();
                    check("dut1_tdata", tdata1, e[31:0]);
                    check("dut1_tid", tid1, e[34:32]);
                end
                if (beats1 % 6 == 5 && beats1 / 6 == 191) wrap_due = 1'b1;
                beats1++;
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic push0(input logic [31:0] d, input logic m);
        int k;
        logic ok;
        s_data0 = d; mute0 = m; s_valid0 = 1'b1;
        k = 0; ok = 1'b0;
        while (!ok) begin
            @(negedge clk); ok = s_ready0;
            @(posedge clk); #1;
            k++;
            if (k > 500) begin fail_now("dut0_push_timeout"); break; end
        end
        s_valid0 = 1'b0;
    endtask

    task automatic push1(input logic [143:0] d);
        int k;
        logic ok;
        s_data1 = d; mute1 = 1'b0; s_valid1 = 1'b1;
        k = 0; ok = 1'b0;
        while (!ok) begin
            @(negedge clk); ok = s_ready1;
            @(posedge clk); #1;
            k++;
            if (k > 500) begin fail_now("dut1_push_timeout"); break; end
        end
        s_valid1 = 1'b0;
    endtask

    task automatic expect0(input logic [31:0] d, input logic m);
        q0.push_back({3'd0, exp_sub({d[15:0], 8'h00}, m, 0, cnt0, 1'b0)});
        q0.push_back({3'd1, exp_sub({d[31:16], 8'h00}, m, 1, cnt0, 1'b0)});
        cnt0++;
    endtask

    task automatic drain0();
        int k;
        k = 0;
        while ((q0.size() != 0 || tvalid0) && k < 300) begin @(posedge clk); #1; k++; end
        if (k >= 300) fail_now("dut0_drain_timeout");
        check("dut0_idle_tvalid", tvalid0, 0);
    endtask

    task automatic reset0();
        rst0 = 1'b1; s_valid0 = 1'b0; q0.delete();
        @(posedge clk); #1;
        check("rst_tvalid", tvalid0, 0);
        check("rst_tdata", tdata0, 0);
        check("rst_tid", tid0, 0);
        check("rst_level", level0, 0);
        check("rst_s_ready", s_ready0, 0);
        check("rst_wrap", wrap0, 0);
        @(posedge clk); #1;
        rst0 = 1'b0; cnt0 = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0]  d;
        logic [143:0] d1;
        logic [23:0]  smp;
        rst0 = 1'b1; s_valid0 = 1'b0; mute0 = 1'b0; tready0 = 1'b1; s_data0 = '0;
        rst1 = 1'b1; s_valid1 = 1'b0; mute1 = 1'b0; tready1 = 1'b1; s_data1 = '0;

        // Basic frame, latency and tvalid drop.
        reset0();
        q0.push_back({3'd0, 32'h0800_1001});
        q0.push_back({3'd1, 32'h8000_1003});
        cnt0++;
        push0({16'h0001, 16'h8001}, 1'b0);
        check("latency_t1_tvalid", tvalid0, 0);
        @(posedge clk); #1;
        check("latency_t2_tvalid", tvalid0, 1);
        drain0();

        // Muted frame.
        reset0();
        q0.push_back({3'd0, 32'h9000_0001});
        q0.push_back({3'd1, 32'h9000_0003});
        cnt0++;
        push0({16'h0001, 16'h8001}, 1'b1);
        drain0();

        // Fill to full under backpressure, then stream with a mid-frame stall.
        reset0();
        tready0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = {16'h1000 + 16'(i), 16'h2000 + 16'(i * 257)};
            expect0(d, i == 2);
            push0(d, i == 2);
        end
        check("full_level", level0, 4);
        check("full_s_ready", s_ready0, 0);
        tready0 = 1'b1;
        repeat (3) begin
            @(negedge clk); check("burst_no_gap", tvalid0, 1);
            @(posedge clk); #1;
        end
        tready0 = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_tvalid", tvalid0, 1);
            check("stall_tdata", tdata0, q0[0][31:0]);
            check("stall_tid", tid0, q0[0][34:32]);
        end
        @(posedge clk); #1;
        tready0 = 1'b1;
        repeat (7) begin
            @(negedge clk); check("burst_no_gap", tvalid0, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("burst_end_tvalid", tvalid0, 0);
        check("burst_scoreboard_empty", q0.size(), 0);
        @(posedge clk); #1;

        // Reset while stalled on channel 1 with two frames buffered.
        tready0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = {16'h3000 + 16'(i), 16'h4000 + 16'(i)};
            expect0(d, 1'b0);
            push0(d, 1'b0);
        end
        tready0 = 1'b1;
        @(posedge clk); #1;
        tready0 = 1'b0;
        check("pre_reset_level", level0, 2);
        check("pre_reset_tid", tid0, 1);
        rst0 = 1'b1; q0.delete();
        @(posedge clk); #1;
        check("midrst_tvalid", tvalid0, 0);
        check("midrst_level", level0, 0);
        check("midrst_tdata", tdata0, 0);
        rst0 = 1'b0; cnt0 = 0; tready0 = 1'b1;
        q0.push_back({3'd0, 32'h0567_8001});
        q0.push_back({3'd1, 32'h8123_4003});
        cnt0++;
        push0({16'h1234, 16'h5678}, 1'b0);
        @(posedge clk); #1;
        check("post_rst_preamble", tdata0[3:0], 4'h1);
        check("post_rst_tid", tid0, 0);
        drain0();

        // 6-channel, 24-bit block stream of 193 frames.
        @(posedge clk); #1;
        rst1 = 1'b0;
        for (int f = 0; f < 193; f++) begin
            for (int n = 0; n < 6; n++) begin
                smp = (f == 0 && n == 4) ? 24'hABCDEF : {8'(f), 8'(n), 8'h5A};
                d1[n*24 +: 24] = smp;
                if (f == 0 && n == 4)      q1.push_back({3'd4, 32'h4ABC_DEF1});
                else if (f == 0 && n == 5) q1.push_back({3'd5, 32'hC000_55A3});
                else q1.push_back({3'(n), exp_sub(smp, 1'b0, n, f, f % 192 == 0)});
            end
            push1(d1);
        end
        begin
            int k;
            k = 0;
            while ((q1.size() != 0 || tvalid1) && k < 3000) begin @(posedge clk); #1; k++; end
            if (k >= 3000) fail_now("dut1_drain_timeout");
        end
        @(negedge clk);
        check("dut1_idle_tvalid", tvalid1, 0);
        check("dut1_wrap_count", wrap_seen, 1);
        check("dut1_beats", beats1, 193 * 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_multichannel_stream_packer.md
Name: aes_multichannel_stream_packer

Overview:
- Generalised successor to the single-sample AXIS-AUD packer.
- Accepts whole audio frames (one sample per channel) over an AXI-Stream-style valid/ready input and buffers them in a small frame FIFO.
- Emits one AES3 subframe per channel on the m00_axis_aud master, with:
  - correct even parity
  - per-block channel status
  - validity/mute control
  - back-to-back frames with no idle beats while data is buffered.
- Sits between the synth voice mixer and the audio formatter IP.

Parameters:
- C_NUM_CHANNELS, 2, channels per frame, 1..8.
- C_SAMPLE_WIDTH, 16, input sample width in bits, 16..24.
- C_FIFO_DEPTH, 4, frames buffered, power of two, >=2.
- C_CHANNEL_STATUS, 192'h0, 192-bit channel status block; bit k is sent in frame k.

Ports:
- m00_axis_aud_aclk  in  1  sole clock.
- m00_axis_aud_areset  in  1  synchronous, active-high reset.
- s_frame_tdata  in  C_NUM_CHANNELS*C_SAMPLE_WIDTH  channel n at bits [n*W +: W].
- s_frame_tvalid  in  1  frame valid.
- s_frame_tready  out  1  high when FIFO not full.
- mute  in  1  sampled with each frame; written into FIFO alongside the samples.
- m00_axis_aud_tdata  out  32  AES subframe.
- m00_axis_aud_tid  out  3  channel index.
- m00_axis_aud_tvalid  out  1  subframe valid.
- m00_axis_aud_tready  in  1  downstream ready.
- fifo_level  out  clog2(C_FIFO_DEPTH)+1  frames currently buffered.
- block_wrap  out  1  one-cycle pulse when frame 191 completes.

Behaviour:
- Reset (synchronous, active-high; also applies mid-frame). On the next edge:
  - tvalid=0, tdata=0, tid=0
  - FIFO flushed, fifo_level=0, s_frame_tready=0 during reset
  - channel and frame counters=0, block_wrap=0
  - the next emitted subframe carries BSYNC.
- Input handshake:
  - s_frame_tready = !full.
  - A frame plus its mute bit is written on tvalid&tready.
  - A simultaneous push and pop while full is not permitted; ready is low when full.
- FSM, IDLE:
  - tvalid=0.
  - If FIFO is non-empty: pop one frame into the holding register, drive channel 0 subframe with tvalid=1, go to SEND.
- FSM, SEND:
  - tdata and tid hold stable while tvalid & !tready.
  - On handshake with channel < N-1: advance to the next channel's subframe next cycle.
  - On handshake with channel = N-1:
    - frame_counter increments, wrapping 191->0; block_wrap pulses on the wrap.
    - If FIFO is non-empty: pop and present channel 0 of the next frame the next cycle (zero bubble).
    - Otherwise: tvalid=0, go to IDLE.
- Latency: a frame accepted at cycle t into an empty FIFO while IDLE gives tvalid=1 at t+2.
- Subframe format:
  - [3:0] preamble:
    - even channel in frame 0: BSYNC=4'h1
    - even channel otherwise: SF1SYNC=4'h2
    - odd channel: SF2SYNC=4'h3
  - [27:4] audio word: sample left-justified, MSB at bit 27, zero-padded below.
  - [28] V = frame mute bit.
  - [29] U = 0.
  - [30] C = C_CHANNEL_STATUS[frame_counter], identical for all channels of a frame.
  - [31] P = even parity over bits [30:4], so bits [31:4] have an even count of ones.
- Mute: audio word forced to zero, V=1; counters and preambles proceed normally.
- C_NUM_CHANNELS=1: every subframe is channel 0; the frame counter advances every beat.
- tid width 3: channels 0..7 only.

Decomposition:
- Package aes_aud_pkg:
  - preamble constants BSYNC/SF1SYNC/SF2SYNC
  - bit-position constants P/C/U/V and the audio word MSB/LSB
  - AES_BLOCK_FRAMES=192
  - a parity function.
- Sub-module aud_frame_fifo:
  - synchronous FIFO, width C_NUM_CHANNELS*C_SAMPLE_WIDTH+1, depth C_FIFO_DEPTH
  - full/empty/level outputs
  - synchronous active-high reset.
- The top level contains the FSM, counters and subframe formatter.

Test Plan:
- Reset, then one frame {ch1=16'h0001, ch0=16'h8001}, mute=0, tready=1:
  - beat 1: tdata=32'h0800_1001, tid=0
  - beat 2: tdata=32'h8000_1003, tid=1
  - then tvalid=0.
  - Confirm tvalid rises at t+2.
- Same frame with mute=1: ch0 tdata=32'h9000_0001, ch1 tdata=32'h9000_0003.
- Push 4 frames with tready=1:
  - 8 contiguous beats with no tvalid gap; s_frame_tready low when fifo_level=4.
  - Hold tready=0 for 5 cycles mid-frame: tdata/tid stable throughout.
- Stream 193 frames with C_CHANNEL_STATUS bit0=1, others 0:
  - frame 0: C=1, BSYNC.
  - frames 1..191: SF1SYNC, C=0.
  - block_wrap pulses after frame 191.
  - frame 192: BSYNC, C=1.
- C_NUM_CHANNELS=6, C_SAMPLE_WIDTH=24, sample 24'hABCDEF on ch4:
  - tid=4, tdata[27:4]=24'hABCDEF, tdata[3:0]=4'h1 in frame 0
  - ch5 preamble 4'h3.
- Assert reset during a tready=0 stall on channel 1 with 2 frames buffered:
  - next cycle tvalid=0, fifo_level=0.
  - After release, push one frame: first beat has BSYNC, tid=0.
